sram_controller: RTL and testbench

Responder for the data-memory port of the pipelined ARM core: accepts the MEM stage's word read/write request (`mem_r_en`/`mem_w_en`, ALU-result address, Rm value) and services it on an external 16-bit asynchronous SRAM. Each 32-bit access takes two halfword phases. `ready` is the MEM stage's freeze signal: while it is low, the whole pipeline holds.

---
 rtl/sram_controller_if.sv | 20 ++
 rtl/sram_controller.sv | 123 ++++++++++++
 tb/tb_sram_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// Request/response bundle between the MEM pipeline stage and the SRAM controller.
// While ready is low the MEM stage must hold its request steady.
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// Services 32-bit word loads/stores from the MEM stage as two 16-bit phases on an
// asynchronous SRAM; ready doubles as the pipeline freeze signal.
module sram_controller #(
    parameter int unsigned BASE_ADDR    = 1024,
    parameter int unsigned PHASE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave bus,
    inout  wire  [15:0]      sram_dq,
    output logic [17:0]      sram_addr,
    output logic             sram_we_n,
    output logic             sram_oe_n,
    output logic             sram_ce_n,
    output logic             sram_ub_n,
    output logic             sram_lb_n
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST = 4'(PHASE_CYCLES - 1);

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic        is_write_reg;
    logic [16:0] word_reg;
    logic [31:0] wdata_reg;
    logic [31:0] shadow_reg;
    logic [31:0] read_data_reg;
    logic        dq_oe_reg;
    logic [15:0] dq_out_reg;

    logic [31:0] offset;
    logic [16:0] word_calc;
    logic        req;
    logic        last_cycle;

    // Addresses below BASE_ADDR or beyond the SRAM simply wrap modulo 2^17 words.
    assign offset     = bus.address - 32'(BASE_ADDR);
    assign word_calc  = 17'(offset >> 2);
    assign req        = bus.wr_en | bus.rd_en;
    assign last_cycle = (cnt_reg == LAST);

    assign bus.ready     = ((state_reg == IDLE) && !req) || (state_reg == DONE);
    assign bus.read_data = ((state_reg == DONE) && !is_write_reg) ? shadow_reg : read_data_reg;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_dq
            assign sram_dq[gi] = dq_oe_reg ? dq_out_reg[gi] : 1'bz;
        end
    endgenerate

    // Strobes, address and bus drive are registered from the transition into each
    // state, so they are already valid in the first cycle of a phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            is_write_reg  <= 1'b0;
            word_reg      <= '0;
            wdata_reg     <= '0;
            shadow_reg    <= '0;
            read_data_reg <= '0;
            dq_oe_reg     <= 1'b0;
            dq_out_reg    <= '0;
            sram_addr     <= '0;
            sram_we_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_ce_n     <= 1'b1;
            sram_ub_n     <= 1'b1;
            sram_lb_n     <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        state_reg    <= LOW;
                        cnt_reg      <= '0;
                        is_write_reg <= bus.wr_en;
                        word_reg     <= word_calc;
                        wdata_reg    <= bus.write_data;
                        sram_addr    <= {word_calc, 1'b0};
                        sram_ce_n    <= 1'b0;
                        sram_ub_n    <= 1'b0;
                        sram_lb_n    <= 1'b0;
                        sram_oe_n    <= bus.wr_en;
                        sram_we_n    <= !bus.wr_en;
                        dq_oe_reg    <= bus.wr_en;
                        dq_out_reg   <= bus.write_data[15:0];
                    end
                end
                LOW, HIGH: begin
                    if (last_cycle) begin
                        cnt_reg <= '0;
                        if (state_reg == LOW) begin
                            if (!is_write_reg) shadow_reg[15:0] <= sram_dq;
                            state_reg  <= HIGH;
                            sram_addr  <= {word_reg, 1'b1};
                            sram_we_n  <= !is_write_reg;
                            dq_out_reg <= wdata_reg[31:16];
                        end else begin
                            if (!is_write_reg) shadow_reg[31:16] <= sram_dq;
                            state_reg <= DONE;
                            sram_we_n <= 1'b1;
                            sram_oe_n <= 1'b1;
                            sram_ce_n <= 1'b1;
                            sram_ub_n <= 1'b1;
                            sram_lb_n <= 1'b1;
                            dq_oe_reg <= 1'b0;
                        end
                    end else begin
                        cnt_reg   <= cnt_reg + 4'd1;
                        // WE rises one cycle before the phase ends so address/data are held across it.
                        sram_we_n <= !is_write_reg || ((cnt_reg + 4'd1) == LAST);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    if (!is_write_reg) read_data_reg <= shadow_reg;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: a behavioural async SRAM on the bus, a table of
// word accesses, plus hand-written back-to-back and reset-mid-access sequences.
module tb_sram_controller;
    localparam int P = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sram_controller_if bus();
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    sram_controller #(.BASE_ADDR(1024), .PHASE_CYCLES(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sram_dq   (sram_dq),
        .sram_addr (sram_addr),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n),
        .sram_ce_n (sram_ce_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n)
    );

    // Asynchronous SRAM: drives while selected and output-enabled, stores on WE rising edge.
    logic [15:0] mem [0:262143];
    logic        drive_en;
    assign drive_en = !sram_ce_n && !sram_oe_n && sram_we_n;
    assign sram_dq  = drive_en ? mem[sram_addr] : 16'bz;
    always @(posedge sram_we_n) begin
        if (!sram_ce_n) mem[sram_addr] <= sram_dq;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] lo;
        logic [17:0] hi;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[8];

    // Caller must be just after a rising edge; returns just after the DONE->IDLE edge.
    task automatic run_access(input string tag, input vec_t v);
        logic [19:0] rdy_b, we_b, oe_b, ce_b;
        logic [17:0] a_lo, a_hi;
        logic [31:0] rd;
        int          done_t;
        rdy_b = '0; we_b = '0; oe_b = '0; ce_b = '0;
        a_lo = '0; a_hi = '0; rd = '0; done_t = -1;
        bus.wr_en = v.w; bus.rd_en = v.r; bus.address = v.addr; bus.write_data = v.wdata;
        for (int t = 0; t < 20 && done_t < 0; t++) begin
            @(negedge clk);
            rdy_b[t] = bus.ready;
            we_b[t]  = !sram_we_n;
            oe_b[t]  = !sram_oe_n;
            ce_b[t]  = !sram_ce_n;
            if (t == 1)     a_lo = sram_addr;
            if (t == P + 1) a_hi = sram_addr;
            if (bus.ready) begin
                done_t = t;
                rd = bus.read_data;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        $display("txn %s w=%b r=%b addr=%h wdata=%h done_t=%0d sram_lo=%h sram_hi=%h rdata=%h",
                 tag, v.w, v.r, v.addr, v.wdata, done_t, a_lo, a_hi, rd);
        check({tag, " done_cycle"}, 32'(done_t), 32'd5);
        check({tag, " ready_pattern"}, 32'(rdy_b), 32'h20);
        check({tag, " ce_low_pattern"}, 32'(ce_b), 32'h1E);
        check({tag, " we_low_pattern"}, 32'(we_b), v.w ? 32'h0A : 32'h00);
        check({tag, " oe_low_pattern"}, 32'(oe_b), v.w ? 32'h00 : 32'h1E);
        check({tag, " addr_low_phase"}, 32'(a_lo), 32'(v.lo));
        check({tag, " addr_high_phase"}, 32'(a_hi), 32'(v.hi));
        if (v.w) begin
            check({tag, " mem_low_half"}, 32'(mem[v.lo]), 32'(v.wdata[15:0]));
            check({tag, " mem_high_half"}, 32'(mem[v.hi]), 32'(v.wdata[31:16]));
        end else begin
            check({tag, " read_data"}, rd, v.rdata);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] rdy_b;
        logic [31:0] rd5, rd11;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = '0; bus.write_data = '0;

        vecs[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 18'h00000, 18'h00001, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'd1024, 32'h0,        18'h00000, 18'h00001, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 32'd1028, 32'hCAFEF00D, 18'h00002, 18'h00003, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, 18'h3FFFE, 18'h3FFFF, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 32'd1028, 32'h0,        18'h00002, 18'h00003, 32'hCAFEF00D};
        vecs[5] = '{1'b0, 1'b1, 32'd1020, 32'h0,        18'h3FFFE, 18'h3FFFF, 32'hA5A55A5A};
        vecs[6] = '{1'b1, 1'b1, 32'd1032, 32'h12345678, 18'h00004, 18'h00005, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 32'd1032, 32'h0,        18'h00004, 18'h00005, 32'h12345678};

        // Idle after reset
        #22 rst = 1'b1;
        @(negedge clk);
        $display("txn idle_after_reset ready=%b read_data=%h ce=%b we=%b oe=%b addr=%h",
                 bus.ready, bus.read_data, sram_ce_n, sram_we_n, sram_oe_n, sram_addr);
        check("idle ready", 32'(bus.ready), 32'd1);
        check("idle read_data", bus.read_data, 32'h0);
        check("idle strobes", {27'd0, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check("idle sram_addr", 32'(sram_addr), 32'h0);

        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            run_access($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-to-back reads with the request held through the freeze
        bus.rd_en = 1'b1; bus.address = 32'd1024;
        rdy_b = '0; rd5 = '0; rd11 = '0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            rdy_b[t] = bus.ready;
            if (t == 5)  rd5  = bus.read_data;
            if (t == 11) rd11 = bus.read_data;
            @(posedge clk); #1;
            if (t == 5) bus.address = 32'd1028;
        end
        bus.rd_en = 1'b0;
        $display("txn back_to_back ready_bits=%h rd_t5=%h rd_t11=%h", rdy_b, rd5, rd11);
        check("b2b ready_pattern", 32'(rdy_b), 32'h820);
        check("b2b first_read", rd5, 32'hDEADBEEF);
        check("b2b second_read", rd11, 32'hCAFEF00D);

        // Reset during the HIGH phase of a read
        @(posedge clk); #1;
        bus.rd_en = 1'b1; bus.address = 32'd1028;
        for (int t = 0; t < 4; t++) @(negedge clk);
        check("rst_mid oe_active_before", 32'(sram_oe_n), 32'd0);
        check("rst_mid addr_before", 32'(sram_addr), 32'h3);
        rst = 1'b0;
        #1;
        $display("txn reset_mid_read ce=%b oe=%b we=%b read_data=%h addr=%h",
                 sram_ce_n, sram_oe_n, sram_we_n, bus.read_data, sram_addr);
        check("rst_mid strobes", {27'd0, sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check("rst_mid read_data", bus.read_data, 32'h0);
        check("rst_mid sram_addr", 32'(sram_addr), 32'h0);
        bus.rd_en = 1'b0;
        #1;
        check("rst_mid ready_idle", 32'(bus.ready), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst ready", 32'(bus.ready), 32'd1);
        check("post_rst ce", 32'(sram_ce_n), 32'd1);
        @(negedge clk);
        check("post_rst ready_held", 32'(bus.ready), 32'd1);
        @(posedge clk); #1;
        run_access("post_rst_read", vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
